// File: rtl/fpu_pkg.sv
// Shared FP32 definitions for the multiplier scheduler slice.
package fpu_pkg;

  localparam int FP_W = 32;

  typedef logic [FP_W-1:0] fp32_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request found when
// searching upward from ptr, wrapping at N. Purely combinational.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  logic found_s;
  int   idx_s;

  // Priority search starting at the pointer position.
  always_comb begin
    gnt     = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int i = 0; i < N; i++) begin
      idx_s = (int'(ptr) + i) % N;
      if (!found_s && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/fp_mul_sched.sv
// Shares one pipelined FP32 multiplier among N_REQ requesters. Issues at
// most one operation per cycle, tracks each operation's owner in a tag
// pipe aligned with the multiplier latency, and routes results back.
module fp_mul_sched
  import fpu_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 3,
  parameter int W       = FP_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_result,
  output logic               mul_in_valid,
  output logic [W-1:0]       mul_a,
  output logic [W-1:0]       mul_b,
  input  logic               mul_out_valid,
  input  logic [W-1:0]       mul_result,
  output logic               err,
  output logic [15:0]        done_cnt
);

  localparam int TAG_W = $clog2(N_REQ);
  localparam int NSTG  = MUL_LAT + 1;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
  } tag_t;

  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] busy_q, busy_d;
  tag_t             pipe_q [NSTG];
  tag_t             pipe_d [NSTG];
  logic             mul_in_valid_q, mul_in_valid_d;
  logic [W-1:0]     mul_a_q, mul_a_d;
  logic [W-1:0]     mul_b_q, mul_b_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [W-1:0]     rsp_result_q, rsp_result_d;
  logic             err_q, err_d;
  logic [15:0]      done_cnt_q, done_cnt_d;

  logic [N_REQ-1:0] elig_s;
  logic [N_REQ-1:0] gnt_s;
  logic [TAG_W-1:0] gnt_idx_s;
  logic             hs_s;
  tag_t             out_s;

  assign elig_s = req_valid & ~busy_q;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req (elig_s),
    .ptr (ptr_q),
    .gnt (gnt_s)
  );

  // Ready is the grant itself; held low while reset is asserted.
  assign req_ready = gnt_s & {N_REQ{rstn}};
  assign hs_s      = |gnt_s;
  assign out_s     = pipe_q[NSTG-1];

  // One-hot grant to index encoder.
  always_comb begin
    gnt_idx_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_s[i]) begin
        gnt_idx_s = TAG_W'(i);
      end else begin
        gnt_idx_s = gnt_idx_s;
      end
    end
  end

  // Next-state: issue, tag pipe shift, response routing and error check.
  always_comb begin
    ptr_d          = ptr_q;
    busy_d         = busy_q;
    mul_in_valid_d = 1'b0;
    mul_a_d        = mul_a_q;
    mul_b_d        = mul_b_q;
    rsp_valid_d    = '0;
    rsp_result_d   = rsp_result_q;
    done_cnt_d     = done_cnt_q;
    err_d          = err_q | (mul_out_valid != out_s.vld);

    pipe_d[0].vld = hs_s;
    pipe_d[0].tag = gnt_idx_s;
    for (int s = 1; s < NSTG; s++) begin
      pipe_d[s] = pipe_q[s-1];
    end

    // Response side first so a same-edge issue can never be masked.
    if (out_s.vld) begin
      rsp_valid_d       = {{(N_REQ-1){1'b0}}, 1'b1} << out_s.tag;
      rsp_result_d      = mul_result;
      busy_d[out_s.tag] = 1'b0;
      done_cnt_d        = done_cnt_q + 16'd1;
    end else begin
      rsp_valid_d = '0;
    end

    if (hs_s) begin
      mul_in_valid_d    = 1'b1;
      mul_a_d           = req_a[gnt_idx_s*W +: W];
      mul_b_d           = req_b[gnt_idx_s*W +: W];
      busy_d[gnt_idx_s] = 1'b1;
      if (gnt_idx_s == TAG_W'(N_REQ-1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx_s + TAG_W'(1);
      end
    end else begin
      mul_in_valid_d = 1'b0;
    end
  end

  // State registers; reset discards all in-flight operations.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q          <= '0;
      busy_q         <= '0;
      mul_in_valid_q <= 1'b0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      rsp_valid_q    <= '0;
      rsp_result_q   <= '0;
      err_q          <= 1'b0;
      done_cnt_q     <= 16'd0;
      for (int s = 0; s < NSTG; s++) begin
        pipe_q[s] <= '0;
      end
    end else begin
      ptr_q          <= ptr_d;
      busy_q         <= busy_d;
      mul_in_valid_q <= mul_in_valid_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      err_q          <= err_d;
      done_cnt_q     <= done_cnt_d;
      for (int s = 0; s < NSTG; s++) begin
        pipe_q[s] <= pipe_d[s];
      end
    end
  end

  assign mul_in_valid = mul_in_valid_q;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign err          = err_q;
  assign done_cnt     = done_cnt_q;

endmodule

// File: tb/tb_fp_mul_sched.sv
// Directed bench for fp_mul_sched with a behavioural 3-cycle FP32 multiplier.
module tb_fp_mul_sched;

  localparam int N   = 4;
  localparam int LAT = 3;
  localparam int W   = 32;

  logic           clk;
  logic           rstn;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_result;
  logic           mul_in_valid;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic           mul_out_valid;
  logic [W-1:0]   mul_result;
  logic           err;
  logic [15:0]    done_cnt;

  logic           drop_en;
  logic           spur_en;
  logic           pv [LAT];
  logic [W-1:0]   pd [LAT];

  int n_cmp;
  int n_fail;
  int exp_done;

  fp_mul_sched #(.N_REQ(N), .MUL_LAT(LAT), .W(W)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .rsp_valid     (rsp_valid),
    .rsp_result    (rsp_result),
    .mul_in_valid  (mul_in_valid),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_out_valid (mul_out_valid),
    .mul_result    (mul_result),
    .err           (err),
    .done_cnt      (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Normal-operand FP32 multiply, truncating.
  function automatic logic [31:0] fmul32(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          e;
    logic [47:0] ma;
    logic [47:0] mb;
    logic [47:0] m;
    logic [22:0] f;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
    ma = {24'd0, 1'b1, a[22:0]};
    mb = {24'd0, 1'b1, b[22:0]};
    m  = ma * mb;
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (m[47]) begin
      e = e + 1;
      f = m[46:24];
    end else begin
      f = m[45:23];
    end
    return {s, e[7:0], f};
  endfunction

  // Multiplier model: LAT-deep pipeline sharing clk/rstn.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LAT; i++) begin
        pv[i] <= 1'b0;
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= mul_in_valid;
      pd[0] <= fmul32(mul_a, mul_b);
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign mul_out_valid = (pv[LAT-1] & ~drop_en) | spur_en;
  assign mul_result    = pd[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"},  32'(req_ready), 32'd0);
    chk({tag, "_rspv"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rspr"}, rsp_result, 32'd0);
    chk({tag, "_miv"},  32'(mul_in_valid), 32'd0);
    chk({tag, "_ma"},   mul_a, 32'd0);
    chk({tag, "_mb"},   mul_b, 32'd0);
    chk({tag, "_err"},  32'(err), 32'd0);
    chk({tag, "_cnt"},  32'(done_cnt), 32'd0);
  endtask

  // Single request on idx; checks issue timing and response at T+5.
  task automatic run_single(input int idx, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] e, input logic drop, input logic exp_err);
    logic [N-1:0] oh;
    oh = 4'b0001 << idx;
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_valid = oh;
    #1;
    chk("single_rdy", 32'(req_ready), 32'(oh));
    nxt();
    req_valid = '0;
    #1;
    chk("single_miv", 32'(mul_in_valid), 32'd1);
    chk("single_mul_a", mul_a, a);
    chk("single_mul_b", mul_b, b);
    for (int k = 2; k <= 4; k++) begin
      nxt();
      if (k == 4) drop_en = drop;
      #1;
      chk("single_early_rsp", 32'(rsp_valid), 32'd0);
    end
    nxt();
    drop_en = 1'b0;
    #1;
    exp_done++;
    chk("single_rspv", 32'(rsp_valid), 32'(oh));
    chk("single_result", rsp_result, e);
    chk("single_cnt", 32'(done_cnt), 32'(exp_done));
    chk("single_err", 32'(err), 32'(exp_err));
    nxt();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req_valid = '0;
    #1;
    chk_all_zero("rst");
    nxt();
    nxt();
    rstn = 1'b1;
    exp_done = 0;
  endtask

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  vec_t tv [6];

  initial begin
    logic [N-1:0] er;
    logic [N-1:0] es;
    n_cmp = 0; n_fail = 0; exp_done = 0;
    tv[0] = '{0, 32'h3FC00000, 32'h3FC00000, 32'h40100000};
    tv[1] = '{1, 32'h40000000, 32'h40400000, 32'h40C00000};
    tv[2] = '{2, 32'hC0000000, 32'h40400000, 32'hC0C00000};
    tv[3] = '{3, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    tv[4] = '{0, 32'h3F000000, 32'h40800000, 32'h40000000};
    tv[5] = '{2, 32'h3FC00000, 32'hBF000000, 32'hBF400000};

    rstn = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    drop_en = 1'b0; spur_en = 1'b0;
    #2;
    chk_all_zero("por");
    nxt(); nxt();
    rstn = 1'b1;
    nxt();

    // All four valid with ptr=0: grants 0..3, responses 5..8.
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 32'h40000000;
      req_b[i*W +: W] = 32'h40400000;
    end
    req_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      #1;
      er = (c < 4) ? (4'b0001 << c) : 4'b0000;
      es = (c >= 5 && c <= 8) ? (4'b0001 << (c - 5)) : 4'b0000;
      chk("all4_rdy", 32'(req_ready), 32'(er));
      chk("all4_rspv", 32'(rsp_valid), 32'(es));
      if (es != 4'b0000) begin
        exp_done++;
        chk("all4_result", rsp_result, 32'h40C00000);
        chk("all4_cnt", 32'(done_cnt), 32'(exp_done));
      end
      nxt();
      if (c < 4) req_valid[c] = 1'b0;
    end

    for (int i = 0; i < 6; i++) begin
      run_single(tv[i].idx, tv[i].a, tv[i].b, tv[i].e, 1'b0, 1'b0);
    end

    // Requester 0 held valid: re-grant every 5 cycles, in its rsp cycle.
    req_a[0 +: W] = 32'h3F800000;
    req_b[0 +: W] = 32'h40400000;
    for (int c = 0; c < 22; c++) begin
      req_valid = (c <= 15) ? 4'b0001 : 4'b0000;
      #1;
      er = (c <= 15 && c % 5 == 0) ? 4'b0001 : 4'b0000;
      es = (c >= 5 && c <= 20 && c % 5 == 0) ? 4'b0001 : 4'b0000;
      chk("reissue_rdy", 32'(req_ready), 32'(er));
      chk("reissue_rspv", 32'(rsp_valid), 32'(es));
      if (es != 4'b0000) begin
        exp_done++;
        chk("reissue_result", rsp_result, 32'h40400000);
        chk("reissue_cnt", 32'(done_cnt), 32'(exp_done));
      end
      nxt();
    end

    // Move ptr to 2 via a grant to requester 1.
    run_single(1, 32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 1'b0);

    // Fairness: requesters 1 and 3 continuously valid, ptr=2.
    for (int c = 0; c < 18; c++) begin
      req_valid = (c <= 11) ? 4'b1010 : 4'b0000;
      #1;
      if (c <= 11 && c % 5 == 0)      er = 4'b1000;
      else if (c <= 11 && c % 5 == 1) er = 4'b0010;
      else                            er = 4'b0000;
      if (c >= 5 && c <= 16 && c % 5 == 0)      es = 4'b1000;
      else if (c >= 6 && c <= 16 && c % 5 == 1) es = 4'b0010;
      else                                      es = 4'b0000;
      chk("fair_rdy", 32'(req_ready), 32'(er));
      chk("fair_rspv", 32'(rsp_valid), 32'(es));
      if (es != 4'b0000) begin
        exp_done++;
        chk("fair_cnt", 32'(done_cnt), 32'(exp_done));
      end
      nxt();
    end

    // Dropped mul_out_valid: response still delivered, err sticks.
    run_single(2, 32'h40400000, 32'h40400000, 32'h41100000, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      nxt();
      #1;
      chk("drop_err_sticky", 32'(err), 32'd1);
    end

    // Spurious mul_out_valid: err set, no response.
    do_reset();
    nxt();
    #1;
    chk("spur_err_before", 32'(err), 32'd0);
    spur_en = 1'b1;
    nxt();
    spur_en = 1'b0;
    #1;
    chk("spur_err", 32'(err), 32'd1);
    chk("spur_rspv", 32'(rsp_valid), 32'd0);
    chk("spur_cnt", 32'(done_cnt), 32'd0);
    nxt();
    #1;
    chk("spur_rspv_late", 32'(rsp_valid), 32'd0);
    chk("spur_err_sticky", 32'(err), 32'd1);
    do_reset();

    // Reset with three operations in flight.
    req_valid = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("inflight_rdy", 32'(req_ready), 32'(4'b0001 << c));
      nxt();
      req_valid[c] = 1'b0;
    end
    do_reset();
    for (int c = 0; c < 8; c++) begin
      nxt();
      #1;
      chk("post_rst_rspv", 32'(rsp_valid), 32'd0);
      chk("post_rst_cnt", 32'(done_cnt), 32'd0);
      chk("post_rst_err", 32'(err), 32'd0);
    end
    run_single(3, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
